// File: rtl/wb_stage_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_stage_regfile_if
//   Signal bundle between the pipeline and the write-back / register-file block.
//   It carries the MEM/WB result sources, the decode-stage read ports, the
//   EX-stage forwarding indices and selects, and the committed-write counter.
//
//   Modports
//     master : the pipeline side. It drives the write-back controls, the result
//              sources and all indices, and it observes the read data, resultW,
//              the forward selects and wbCount.
//     slave  : the wb_stage_regfile side, with the opposite directions.
//
//   Timing contract
//     There is no valid/ready handshake on this bundle. A write is offered by
//     regWriteW together with RdW and the selected source. It commits on the
//     posedge where regWriteW=1 and RdW!=0, and it is never stalled or refused.
//     Every output is either combinational from the current inputs or
//     registered state.
// ---------------------------------------------------------------------------
interface wb_stage_regfile_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  // MEM/WB write-back request
  logic              regWriteW;
  logic [1:0]        resultSrcW;
  logic [AW-1:0]     RdW;
  logic [XLEN-1:0]   ALUResultW;
  logic [XLEN-1:0]   RDW;
  logic [XLEN-1:0]   PCPlus4W;
  logic [XLEN-1:0]   extImmW;
  logic [XLEN-1:0]   resultW;

  // decode-stage read ports
  logic [AW-1:0]     Rs1D;
  logic [AW-1:0]     Rs2D;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;

  // EX-stage forwarding
  logic [AW-1:0]     Rs1E;
  logic [AW-1:0]     Rs2E;
  logic [AW-1:0]     RdM;
  logic              regWriteM;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;

  // committed-write counter
  logic [CNT_W-1:0]  wbCount;

  modport master (
    output regWriteW, resultSrcW, RdW, ALUResultW, RDW, PCPlus4W, extImmW,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdM, regWriteM,
    input  resultW, RD1D, RD2D, forwardAE, forwardBE, wbCount
  );

  modport slave (
    input  regWriteW, resultSrcW, RdW, ALUResultW, RDW, PCPlus4W, extImmW,
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdM, regWriteM,
    output resultW, RD1D, RD2D, forwardAE, forwardBE, wbCount
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// ---------------------------------------------------------------------------
// wb_stage_regfile
//   Write-back end of the MEM/WB boundary.
//     - It selects the write-back result from the four MEM/WB sources. This
//       result goes out as resultW, which is also the WB forward source for EX.
//     - It commits the result into the architectural register file. x0 is
//       hard-wired to zero.
//     - It serves two combinational decode read ports. A read whose index
//       matches this cycle's write sees the write data (write-through bypass).
//     - It produces the EX operand forward selects. MEM has priority over WB.
//     - It counts committed writes to registers other than x0.
//
//   Ports
//     clk : clock; all state updates on posedge
//     rst : asynchronous, active-high reset. It clears the registers and the
//           counter, and it forces the read ports to 0 while asserted.
//     bus : wb_stage_regfile_if.slave (the signals are listed in the interface)
//
//   There is no FSM in this block. The only state is the register array and
//   the commit counter.
// ---------------------------------------------------------------------------
module wb_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  wb_stage_regfile_if.slave   bus
);

  localparam int AW = $clog2(NREG);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [XLEN-1:0]  regs [NREG];
  logic [XLEN-1:0]  result;
  logic             commit_en;
  logic [CNT_W-1:0] wb_count;

  // -------------------------------------------------------------------------
  // Result select. Every code picks exactly one source, so an X on an
  // unselected source cannot reach resultW.
  // -------------------------------------------------------------------------
  always_comb begin
    result = '0;
    case (bus.resultSrcW)
      SRC_ALU:  result = bus.ALUResultW;
      SRC_MEM:  result = bus.RDW;
      SRC_LINK: result = bus.PCPlus4W;
      SRC_IMM:  result = bus.extImmW;
      default:  result = '0;
    endcase
  end

  assign bus.resultW = result;

  // A write to x0 is dropped. This keeps x0 at its reset value of zero, and
  // such a write is not counted.
  assign commit_en = bus.regWriteW && (bus.RdW != '0);

  // -------------------------------------------------------------------------
  // Register array. Entry 0 is cleared by reset and never written, so it
  // stays zero. The read ports also force index 0 to zero on their own.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_en) begin
      regs[bus.RdW] <= result;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. While rst is high they read 0, even if a bypass would match.
  // The array is being cleared at that moment, and any write in flight is
  // discarded.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.RD1D = '0;
    if (rst || bus.Rs1D == '0) begin
      bus.RD1D = '0;
    end else if (bus.regWriteW && bus.RdW == bus.Rs1D) begin
      bus.RD1D = result;
    end else begin
      bus.RD1D = regs[bus.Rs1D];
    end
  end

  always_comb begin
    bus.RD2D = '0;
    if (rst || bus.Rs2D == '0) begin
      bus.RD2D = '0;
    end else if (bus.regWriteW && bus.RdW == bus.Rs2D) begin
      bus.RD2D = result;
    end else begin
      bus.RD2D = regs[bus.Rs2D];
    end
  end

  // -------------------------------------------------------------------------
  // EX forwarding. MEM holds the newer value, so it wins over WB. Index 0
  // never forwards because x0 is constant.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.forwardAE = FWD_RF;
    if (bus.regWriteM && bus.RdM != '0 && bus.RdM == bus.Rs1E) begin
      bus.forwardAE = FWD_MEM;
    end else if (bus.regWriteW && bus.RdW != '0 && bus.RdW == bus.Rs1E) begin
      bus.forwardAE = FWD_WB;
    end
  end

  always_comb begin
    bus.forwardBE = FWD_RF;
    if (bus.regWriteM && bus.RdM != '0 && bus.RdM == bus.Rs2E) begin
      bus.forwardBE = FWD_MEM;
    end else if (bus.regWriteW && bus.RdW != '0 && bus.RdW == bus.Rs2E) begin
      bus.forwardBE = FWD_WB;
    end
  end

  // -------------------------------------------------------------------------
  // Committed-write counter. It wraps silently modulo 2^CNT_W.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count <= '0;
    end else if (commit_en) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

  assign bus.wbCount = wb_count;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_stage_regfile
//   Directed bench for wb_stage_regfile.
//     dut   : default parameters (32-bit counter)
//     dut_w : CNT_W=4, used to exercise the counter wrap
//   Inputs change shortly after a negedge. Combinational outputs are sampled
//   1 ns after the inputs change, and state is sampled 1 ns after a posedge.
// ---------------------------------------------------------------------------
module tb_wb_stage_regfile;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  wb_stage_regfile_if #(.XLEN(32), .AW(5), .CNT_W(32)) bus  ();
  wb_stage_regfile_if #(.XLEN(32), .AW(5), .CNT_W(4))  bus4 ();

  wb_stage_regfile #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_stage_regfile #(.XLEN(32), .NREG(32), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- drivers ------------------------------------------------------------
  task automatic idle_inputs();
    bus.regWriteW  = 1'b0;  bus.resultSrcW = 2'b00;  bus.RdW = '0;
    bus.ALUResultW = '0;    bus.RDW = '0;  bus.PCPlus4W = '0;  bus.extImmW = '0;
    bus.Rs1D = '0;  bus.Rs2D = '0;  bus.Rs1E = '0;  bus.Rs2E = '0;
    bus.RdM = '0;   bus.regWriteM = 1'b0;
    bus4.regWriteW  = 1'b0;  bus4.resultSrcW = 2'b00;  bus4.RdW = '0;
    bus4.ALUResultW = '0;    bus4.RDW = '0;  bus4.PCPlus4W = '0;  bus4.extImmW = '0;
    bus4.Rs1D = '0;  bus4.Rs2D = '0;  bus4.Rs1E = '0;  bus4.Rs2E = '0;
    bus4.RdM = '0;   bus4.regWriteM = 1'b0;
  endtask

  // A single ALU-sourced write on the main DUT. It leaves regWriteW low
  // after the edge.
  task automatic commit_alu(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    bus.regWriteW = 1'b1; bus.resultSrcW = 2'b00; bus.RdW = rd; bus.ALUResultW = val;
    @(posedge clk); #1;
    bus.regWriteW = 1'b0;
  endtask

  // ---- tests --------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    commit_alu(5'd1, 32'h55);
    bus.Rs1D = 5'd1; #1;
    n_vec++;
    if (bus.RD1D !== 32'h55) begin
      n_err++; $display("FAIL pre_reset_x1: got %h want %h", bus.RD1D, 32'h55);
    end
    n_vec++;
    if (bus.wbCount !== 32'd1) begin
      n_err++; $display("FAIL pre_reset_count: got %0d want 1", bus.wbCount);
    end
    // Assert reset mid-cycle while a write to x2 is offered.
    @(negedge clk); #2;
    bus.regWriteW = 1'b1; bus.RdW = 5'd2; bus.ALUResultW = 32'h77; bus.Rs2D = 5'd2;
    rst = 1'b1; #1;
    n_vec++;
    if (bus.RD1D !== 32'h0 || bus.RD2D !== 32'h0) begin
      n_err++; $display("FAIL reset_rd: got %h/%h want 0/0", bus.RD1D, bus.RD2D);
    end
    n_vec++;
    if (bus.wbCount !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", bus.wbCount);
    end
    @(posedge clk); #1;
    @(negedge clk);
    bus.regWriteW = 1'b0;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bus.Rs1D = 5'(i); #1;
      n_vec++;
      if (bus.RD1D !== 32'h0) begin
        n_err++; $display("FAIL reset_clear_x%0d: got %h want 0", i, bus.RD1D);
      end
    end
    n_vec++;
    if (bus.wbCount !== 32'd0) begin
      n_err++; $display("FAIL reset_discard_count: got %0d want 0", bus.wbCount);
    end
  endtask

  task automatic test_mux();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
    bus.ALUResultW = 32'h11; bus.RDW = 32'h22; bus.PCPlus4W = 32'h33; bus.extImmW = 32'h44;
    bus.Rs1D = 5'd5;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus.regWriteW = 1'b1; bus.RdW = 5'd5; bus.resultSrcW = 2'(s); #1;
      n_vec++;
      if (bus.resultW !== exp_v[s]) begin
        n_err++; $display("FAIL mux_result_%0d: got %h want %h", s, bus.resultW, exp_v[s]);
      end
      @(posedge clk); #1;
      bus.regWriteW = 1'b0; #1;
      n_vec++;
      if (bus.RD1D !== exp_v[s]) begin
        n_err++; $display("FAIL mux_commit_%0d: got %h want %h", s, bus.RD1D, exp_v[s]);
      end
    end
    n_vec++;
    if (bus.wbCount !== 32'd4) begin
      n_err++; $display("FAIL mux_count: got %0d want 4", bus.wbCount);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    bus.regWriteW = 1'b1; bus.RdW = 5'd0; bus.resultSrcW = 2'b00; bus.ALUResultW = 32'hDEAD;
    bus.Rs1D = 5'd0; bus.Rs1E = 5'd0; bus.RdM = 5'd0; bus.regWriteM = 1'b1; #1;
    n_vec++;
    if (bus.RD1D !== 32'h0) begin
      n_err++; $display("FAIL x0_bypass: got %h want 0", bus.RD1D);
    end
    n_vec++;
    if (bus.forwardAE !== 2'b00) begin
      n_err++; $display("FAIL x0_forward: got %b want 00", bus.forwardAE);
    end
    @(posedge clk); #1;
    bus.regWriteW = 1'b0; bus.regWriteM = 1'b0; #1;
    n_vec++;
    if (bus.RD1D !== 32'h0) begin
      n_err++; $display("FAIL x0_read: got %h want 0", bus.RD1D);
    end
    n_vec++;
    if (bus.wbCount !== 32'd4) begin
      n_err++; $display("FAIL x0_count: got %0d want 4", bus.wbCount);
    end
  endtask

  task automatic test_bypass();
    commit_alu(5'd7, 32'h1);
    bus.Rs1D = 5'd7; bus.Rs2D = 5'd7; #1;
    n_vec++;
    if (bus.RD1D !== 32'h1) begin
      n_err++; $display("FAIL bypass_pre: got %h want 1", bus.RD1D);
    end
    @(negedge clk);
    bus.regWriteW = 1'b1; bus.RdW = 5'd7; bus.resultSrcW = 2'b00; bus.ALUResultW = 32'hABCD; #1;
    n_vec++;
    if (bus.RD1D !== 32'hABCD || bus.RD2D !== 32'hABCD) begin
      n_err++; $display("FAIL bypass_same_cycle: got %h/%h want abcd/abcd", bus.RD1D, bus.RD2D);
    end
    @(posedge clk); #1;
    bus.regWriteW = 1'b0; bus.ALUResultW = 32'h0; #1;
    n_vec++;
    if (bus.RD1D !== 32'hABCD || bus.RD2D !== 32'hABCD) begin
      n_err++; $display("FAIL bypass_after: got %h/%h want abcd/abcd", bus.RD1D, bus.RD2D);
    end
    n_vec++;
    if (bus.wbCount !== 32'd6) begin
      n_err++; $display("FAIL bypass_count: got %0d want 6", bus.wbCount);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    bus.Rs1E = 5'd3; bus.Rs2E = 5'd4; bus.RdM = 5'd3; bus.regWriteM = 1'b1;
    bus.RdW = 5'd3; bus.regWriteW = 1'b1; #1;
    n_vec++;
    if (bus.forwardAE !== 2'b10 || bus.forwardBE !== 2'b00) begin
      n_err++; $display("FAIL fwd_mem_prio: got %b/%b want 10/00", bus.forwardAE, bus.forwardBE);
    end
    bus.regWriteM = 1'b0; #1;
    n_vec++;
    if (bus.forwardAE !== 2'b01) begin
      n_err++; $display("FAIL fwd_wb: got %b want 01", bus.forwardAE);
    end
    bus.RdW = 5'd4; #1;
    n_vec++;
    if (bus.forwardAE !== 2'b00 || bus.forwardBE !== 2'b01) begin
      n_err++; $display("FAIL fwd_wb_b: got %b/%b want 00/01", bus.forwardAE, bus.forwardBE);
    end
    bus.regWriteM = 1'b1; bus.RdM = 5'd4; #1;
    n_vec++;
    if (bus.forwardBE !== 2'b10) begin
      n_err++; $display("FAIL fwd_mem_b: got %b want 10", bus.forwardBE);
    end
    bus.regWriteW = 1'b0; bus.regWriteM = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd0;
    bus4.resultSrcW = 2'b00; bus4.RdW = 5'd1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus4.regWriteW = 1'b1; bus4.ALUResultW = 32'(i);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 4'd1;
      n_vec++;
      if (bus4.wbCount !== exp_cnt) begin
        n_err++; $display("FAIL wrap_count_%0d: got %0d want %0d", i + 1, bus4.wbCount, exp_cnt);
      end
    end
    // Assert reset in the middle of the commit sequence.
    @(negedge clk); #2;
    rst = 1'b1; #1;
    n_vec++;
    if (bus4.wbCount !== 4'd0) begin
      n_err++; $display("FAIL wrap_async_reset: got %0d want 0", bus4.wbCount);
    end
    @(negedge clk);
    bus4.regWriteW = 1'b0;
    rst = 1'b0;
  endtask

  // ---- sequence + report --------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mux();
    test_x0();
    test_bypass();
    test_forward();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
